// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute sequencer feeding the
// control core with an instruction ID and the supervisor MODE bit.
// Optional interrupt injection is enabled by defining SEQ_IRQ_EN.
module control_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic [6:0]  decoded_id,
    input  logic        irq,
    output logic [15:0] ir,
    output logic [6:0]  id,
    output logic        mode,
    output logic        fetch,
    output logic        pc_enable,
    output logic        halted,
    output logic        irq_ack
);

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEMWAIT = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    localparam logic [6:0] ID_NOP    = 7'd0;
    localparam logic [6:0] ID_SWI    = 7'd72;
    localparam logic [6:0] ID_RETURN = 7'd74;
    localparam logic [6:0] ID_HALT   = 7'd75;
    localparam logic [6:0] ID_RESET  = 7'd100;

    state_t      state_reg, state_next;
    logic [15:0] ir_reg;
    logic [6:0]  id_reg, id_next;
    logic        mode_reg, mode_next;
    logic        irq_taken_reg, irq_taken_next;

    // Loads need a second execute cycle (MEMWAIT) for the memory read.
    function automatic logic is_load(input logic [6:0] v);
        is_load = ((v >= 7'd43) && (v <= 7'd47)) || (v == 7'd49) ||
                  (v == 7'd51) || (v == 7'd53) || (v == 7'd55) ||
                  (v == 7'd68) || (v == 7'd71);
    endfunction

    // State, instruction, ID and mode registers; reset abandons any instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_RESET;
            ir_reg        <= 16'd0;
            id_reg        <= ID_NOP;
            mode_reg      <= 1'b1;
            irq_taken_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            id_reg        <= id_next;
            mode_reg      <= mode_next;
            irq_taken_reg <= irq_taken_next;
            if (state_reg == ST_FETCH) begin
                ir_reg <= instruction;
            end
        end
    end

    // Next-state logic; outputs depend only on registered state, never on inputs.
    always_comb begin
        state_next     = state_reg;
        id_next        = id_reg;
        mode_next      = mode_reg;
        irq_taken_next = irq_taken_reg;
        id             = ID_NOP;
        fetch          = 1'b0;
        pc_enable      = 1'b0;
        halted         = 1'b0;
        case (state_reg)
            ST_RESET: begin
                id         = ID_RESET;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                fetch      = 1'b1;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                // Programs must never be able to drive the core into RESET.
                id_next        = (decoded_id == ID_RESET) ? ID_NOP : decoded_id;
                irq_taken_next = 1'b0;
`ifdef SEQ_IRQ_EN
                // Interrupts only preempt user code and win over HALT.
                if (irq && !mode_reg) begin
                    id_next        = ID_SWI;
                    irq_taken_next = 1'b1;
                end
`endif
                state_next = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                id = id_reg;
                // Mode changes on the edge leaving EXECUTE, so the core sees
                // the old mode for the whole SWI/return execute cycle.
                if (id_reg == ID_SWI) begin
                    mode_next = 1'b1;
                end else if (id_reg == ID_RETURN) begin
                    mode_next = 1'b0;
                end
                if (irq_taken_reg) begin
                    // No PC advance: the interrupted instruction is refetched.
                    state_next = ST_FETCH;
                end else if (is_load(id_reg)) begin
                    state_next = ST_MEMWAIT;
                end else if (id_reg == ID_HALT) begin
                    state_next = ST_HALT;
                end else begin
                    pc_enable  = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_MEMWAIT: begin
                id         = id_reg;
                pc_enable  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                id     = ID_HALT;
                halted = 1'b1;
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

    assign ir   = ir_reg;
    assign mode = mode_reg;

`ifdef SEQ_IRQ_EN
    assign irq_ack = (state_reg == ST_EXECUTE) && irq_taken_reg;
`else
    // Interrupt input is unused in this build.
    logic unused_irq;
    assign unused_irq = irq;
    assign irq_ack    = 1'b0;
`endif

endmodule
